// File: rtl/team_06_sram_pkg.sv
// Shared types and helpers for the audio-effect SRAM responder and its macro model.
// The state encoding and the default geometry live here so the bench and the RTL agree.
package team_06_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sram_state_e;

    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_ACCESS_LAT = 2;

    // Expands a 4-bit byte select into a 32-bit data mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/team_06_sram_bank.sv
// Behavioural single-port SRAM macro: byte-writable array with an ACCESS_LAT-deep read
// pipeline. Contents are deliberately not reset so stored samples survive a logic reset.
module team_06_sram_bank
    import team_06_sram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ACCESS_LAT = DEF_ACCESS_LAT
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem  [2**ADDR_W];
    logic [31:0] r_pipe [ACCESS_LAT];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data appears ACCESS_LAT cycles after the enable cycle.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_pipe[0] <= r_mem[i_addr];
        end
        for (int i = 1; i < ACCESS_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_rdata = r_pipe[ACCESS_LAT-1];

endmodule

// File: rtl/team_06_sram_responder.sv
// Memory-side responder: accepts one-shot read/write requests, sequences the SRAM macro
// through ISSUE and a fixed-length WAIT, and returns masked read data with an ack pulse.
module team_06_sram_responder
    import team_06_sram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ACCESS_LAT = DEF_ACCESS_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       addressOut,
    input  logic [3:0]        select,
    input  logic [31:0]       busAudioWrite,
    output logic [31:0]       busAudioRead,
    output logic              busySRAM,
    output logic              ack,
    output logic              addr_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    sram_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_write;
    logic              r_in_range;
    logic [3:0]        r_sel;
    logic              r_busy;
    logic              r_ack;
    logic              r_addr_err;
    logic [31:0]       r_rdata;
    logic              r_mem_en;
    logic [3:0]        r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic w_req;
    logic w_in_range;

    assign w_req      = read | write;
    assign w_in_range = (addressOut[31:ADDR_W+2] == '0) && (addressOut[1:0] == 2'b00);

    // Out-of-range accesses keep normal timing but never touch the macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_in_range  <= 1'b0;
            r_sel       <= 4'b0000;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_addr_err  <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state     <= ISSUE;
                        r_busy      <= 1'b1;
                        r_is_write  <= write;
                        r_in_range  <= w_in_range;
                        r_sel       <= select;
                        r_mem_en    <= w_in_range;
                        r_mem_we    <= (write && w_in_range) ? select : 4'b0000;
                        r_mem_addr  <= addressOut[ADDR_W+1:2];
                        r_mem_wdata <= busAudioWrite;
                        if (!w_in_range) begin
                            r_addr_err <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_state  <= WAIT;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 4'b0000;
                    r_cnt    <= CNT_W'(ACCESS_LAT - 1);
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                        if (!r_is_write) begin
                            r_rdata <= r_in_range ? (mem_rdata & byte_mask(r_sel)) : 32'h0000_0000;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 4'b0000;
                end
            endcase
        end
    end

    assign busAudioRead = r_rdata;
    assign busySRAM     = r_busy;
    assign ack          = r_ack;
    assign addr_err     = r_addr_err;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

endmodule
